// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - direct-mapped I-cache with 8-word block miss/fill FSM
// Optional ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_fill_ctrl #(
    parameter int SETS        = 32,
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] addr,
    output logic [15:0] inst,
    output logic        stall,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
`ifdef ICACHE_PERF_CNT_EN
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
`endif
    input  logic        mem_valid
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int OFF_W   = $clog2(BLOCK_WORDS);
    localparam int TAG_W   = 16 - 1 - OFF_W - INDEX_W;
    localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_e;

    logic [15:0]        data_mem  [SETS*BLOCK_WORDS];
    logic [TAG_W-1:0]   tag_array [SETS];

    state_e             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
    logic [INDEX_W-1:0] fill_index_q, fill_index_d;
    logic [3:0]         issue_cnt_q, issue_cnt_d;
    logic [3:0]         recv_cnt_q, recv_cnt_d;
    logic               mem_rd_q, mem_rd_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
`ifdef ICACHE_PERF_CNT_EN
    logic [15:0]        hit_cnt_q, hit_cnt_d;
    logic [15:0]        miss_cnt_q, miss_cnt_d;
`endif

    logic [OFF_W-1:0]   addr_off;
    logic [INDEX_W-1:0] addr_index;
    logic [TAG_W-1:0]   addr_tag;
    logic               hit;
    logic               miss;
    logic               data_we;
    logic               tag_we;
    logic [3:0]         issue_nxt;
    logic               unused_addr0;

    assign addr_off     = addr[OFF_W:1];
    assign addr_index   = addr[OFF_W+INDEX_W:OFF_W+1];
    assign addr_tag     = addr[15:OFF_W+INDEX_W+1];
    assign unused_addr0 = addr[0];

    // Zero-cycle lookup; the tag compare is masked by valid so unwritten tags never matter.
    assign hit   = req & valid_q[addr_index] & (tag_array[addr_index] == addr_tag);
    assign miss  = (state_q == S_IDLE) & req & ~hit;
    assign inst  = hit ? data_mem[{addr_index, addr_off}] : 16'h0000;
    assign stall = (state_q == S_IDLE) ? (req & ~hit) : 1'b1;

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign issue_nxt = issue_cnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        fill_tag_d   = fill_tag_q;
        fill_index_d = fill_index_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    state_d      = S_FILL;
                    fill_tag_d   = addr_tag;
                    fill_index_d = addr_index;
                    issue_cnt_d  = 4'd0;
                    recv_cnt_d   = 4'd0;
                    mem_rd_d     = 1'b1;
                    mem_addr_d   = {addr_tag, addr_index, {OFF_W{1'b0}}, 1'b0};
                end
            end
            S_FILL: begin
                // mem_rd/mem_addr are registered, so they are prepared one issue ahead.
                if (issue_cnt_q <= LAST_WORD) begin
                    issue_cnt_d = issue_nxt;
                    mem_rd_d    = (issue_cnt_q < LAST_WORD);
                    if (issue_cnt_q < LAST_WORD) begin
                        mem_addr_d = {fill_tag_q, fill_index_q, issue_nxt[OFF_W-1:0], 1'b0};
                    end
                end
                if (mem_valid) begin
                    data_we    = 1'b1;
                    recv_cnt_d = recv_cnt_q + 4'd1;
                    if (recv_cnt_q == LAST_WORD) begin
                        tag_we                = 1'b1;
                        valid_d[fill_index_q] = 1'b1;
                        state_d               = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ICACHE_PERF_CNT_EN
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == S_IDLE) && hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (miss && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            fill_tag_q   <= '0;
            fill_index_q <= '0;
            issue_cnt_q  <= 4'd0;
            recv_cnt_q   <= 4'd0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            fill_tag_q   <= fill_tag_d;
            fill_index_q <= fill_index_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Storage arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[{fill_index_q, recv_cnt_q[OFF_W-1:0]}] <= mem_data;
        end
        if (tag_we) begin
            tag_array[fill_index_q] <= fill_tag_q;
        end
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - directed + random bench for icache_fill_ctrl with L=4 memory model
module tb_icache_fill_ctrl;
    localparam int SETS = 32;
    localparam int L    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] inst;
    logic        stall;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_valid = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    icache_fill_ctrl #(.SETS(SETS), .BLOCK_WORDS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .addr      (addr),
        .inst      (inst),
        .stall     (stall),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
`ifdef ICACHE_PERF_CNT_EN
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
`endif
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] mem [32768];
    logic        pipe_v [L];
    logic [15:0] pipe_d [L];

    bit          m_valid [SETS];
    int          m_tag   [SETS];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    // Memory: a read seen in cycle c returns its word during cycle c+L.
    always @(negedge clk) begin
        mem_valid = pipe_v[L-1];
        mem_data  = pipe_d[L-1];
        for (int i = L-1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = mem_rd;
        pipe_d[0] = mem[mem_addr[15:1]];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf();
`ifdef ICACHE_PERF_CNT_EN
        chk("hit_cnt", hit_cnt, 16'(exp_hits));
        chk("miss_cnt", miss_cnt, 16'(exp_misses));
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the access completes.
    task automatic fetch(input logic [15:0] a, input int sw_cyc, input logic [15:0] a2,
                         input int rst_cyc);
        int idx;
        int tg;
        logic [15:0] base;
        idx  = (a >> 4) % SETS;
        tg   = a >> (4 + $clog2(SETS));
        base = a & 16'hFFF0;
        req  = 1'b1;
        addr = a;
        @(negedge clk);
        if (m_valid[idx] && m_tag[idx] == tg) begin
            chk("hit_stall", {15'd0, stall}, 16'd0);
            chk("hit_inst", inst, mem[a[15:1]]);
            chk("hit_mem_rd", {15'd0, mem_rd}, 16'd0);
            exp_hits++;
            @(posedge clk); #1;
            return;
        end
        chk("miss_stall_c0", {15'd0, stall}, 16'd1);
        exp_misses++;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                req   = 1'b0;
                #1;
                chk("rst_stall", {15'd0, stall}, 16'd0);
                chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
                model_reset();
                return;
            end
            if (c == sw_cyc) addr = a2;
            @(negedge clk);
            chk("fill_stall", {15'd0, stall}, 16'd1);
            chk("fill_mem_rd", {15'd0, mem_rd}, {15'd0, (c <= 8)});
            if (c <= 8) chk("fill_mem_addr", mem_addr, base + 16'(2 * (c - 1)));
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < L; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 16'h0000;
        end
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {15'd0, stall}, 16'd0);
        chk("reset_inst", inst, 16'h0000);
        chk("reset_mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        chk_perf();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cold miss, post-fill hit, then sequential hits through the block.
        fetch(16'h0000, -1, 16'h0, -1);
        fetch(16'h0000, -1, 16'h0, -1);
        for (int w = 1; w < 8; w++) fetch(16'(2 * w), -1, 16'h0, -1);
        chk_perf();
        fetch(16'h000A, -1, 16'h0, -1);

        // Conflict eviction on index 0.
        fetch(16'h0200, -1, 16'h0, -1);
        fetch(16'h0200, -1, 16'h0, -1);
        fetch(16'h0000, -1, 16'h0, -1);
        fetch(16'h0000, -1, 16'h0, -1);

        // Address change during fill.
        fetch(16'h0010, 5, 16'h0100, -1);
        fetch(16'h0100, -1, 16'h0, -1);
        fetch(16'h0100, -1, 16'h0, -1);
        fetch(16'h0012, -1, 16'h0, -1);
        chk_perf();

        // req low: no miss, no traffic.
        req  = 1'b0;
        addr = 16'h0400;
        repeat (3) begin
            @(negedge clk);
            chk("idle_stall", {15'd0, stall}, 16'd0);
            chk("idle_mem_rd", {15'd0, mem_rd}, 16'd0);
        end
        @(posedge clk); #1;

        // Random fetches over a few tags/indices, bit 0 randomized.
        for (int n = 0; n < 30; n++) begin
            ra = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4) |
                     ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
            fetch(ra, -1, 16'h0, -1);
        end
        chk_perf();

        // Reset in the 6th FILL cycle; late returns must be ignored.
        fetch(16'h0E00, -1, 16'h0, 6);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_stall", {15'd0, stall}, 16'd0);
            chk("post_rst_mem_rd", {15'd0, mem_rd}, 16'd0);
        end
        @(posedge clk); #1;
        chk_perf();
        fetch(16'h0000, -1, 16'h0, -1);
        fetch(16'h0000, -1, 16'h0, -1);
        chk_perf();

        req = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Direct-mapped instruction cache with an integrated miss/fill state machine.
- Sits between the fetch-stage PC register and a multi-cycle pipelined main memory, directly upstream of the IF/ID latch.
- Supplies the fetched instruction on a hit, and asserts a stall to hold the PC and IF/ID on a miss.
- On a miss, fetches the full 8-word block from memory, installs it, and then resumes hitting.

Parameters:
- SETS, 32, number of cache lines; power of two, 2..256. INDEX_W = log2(SETS).
- BLOCK_WORDS, 8, 16-bit words per line; fixed at 8. Not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  fetch request; low during reset or halt.
- addr  in  16  byte address of the fetch (the PC). Bit 0 is ignored.
- inst  out  16  instruction word; valid when req=1 and stall=0.
- stall  out  1  high while the requested word is not available.
- mem_rd  out  1  memory read strobe, one word per cycle.
- mem_addr  out  16  memory byte address accompanying mem_rd.
- mem_data  in  16  returned memory word.
- mem_valid  in  1  mem_data valid. Words return in issue order, after a fixed but unknown latency of 1 cycle or more.

Behaviour:
- Address split:
  - offset = addr[3:1] (word within the block).
  - index = addr[3+INDEX_W:4].
  - tag = addr[15:4+INDEX_W].
- Storage:
  - data array: SETS x 8 x 16 bits, not reset.
  - tag array: SETS x tag width.
  - valid: SETS bits, all cleared on reset.
- Hit = req & valid[index] & (tag_array[index]==tag).
  - Lookup is combinational, with zero-cycle latency.
  - inst = data[index][offset] on a hit, otherwise 16'h0000.
- stall = req & ~hit while in IDLE. stall = 1 in every other state.
- Reset values: state IDLE, stall 0, inst 0, mem_rd 0, mem_addr 0, issue_cnt 0, recv_cnt 0, all valid bits 0.
- IDLE state:
  - On a miss, latch fill_tag and fill_index from addr and clear both counters. Next state is FILL.
  - mem_valid is ignored in IDLE.
- FILL state:
  - While issue_cnt < 8: mem_rd=1 and mem_addr = {fill_tag, fill_index, issue_cnt[2:0], 1'b0}. issue_cnt increments every cycle.
  - Once issue_cnt = 8: mem_rd=0 and mem_addr holds its last value.
  - On each mem_valid (may coincide with an issue cycle), write mem_data to data[fill_index][recv_cnt] and increment recv_cnt.
  - When the 8th word is captured, in the same edge:
    - write tag_array[fill_index] = fill_tag;
    - set valid[fill_index];
    - next state is IDLE.
- Timing: stall drops the cycle after the last word is captured, because that cycle sees a hit in IDLE.
- Miss penalty with memory latency L: 9+L stall cycles, counting the detection cycle.
- addr and req are ignored during FILL. The fill always completes for the latched line, even if addr changes.
- A fill overwrites the line regardless of its previous contents (eviction). valid is not cleared at fill start. Because stall=1 throughout FILL, no stale data is ever consumed.
- Asynchronous reset mid-fill:
  - abort immediately and return to IDLE;
  - mem_rd and stall go to 0;
  - all valid bits clear;
  - any mem_valid arriving after reset is ignored.
- When req=0: no miss is detected, stall=0, and no memory traffic is generated.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined:
  - add output hit_cnt[15:0] and output miss_cnt[15:0];
  - both reset to 0 asynchronously;
  - hit_cnt increments on each IDLE cycle with a hit;
  - miss_cnt increments on each IDLE-to-FILL transition;
  - both saturate at 16'hFFFF.
- When undefined: the ports and counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Bench memory model: L=4. Default SETS=32.
- Cold miss: after reset, req=1, addr=0x0000 at cycle 0.
  - stall=1 for cycles 0..12.
  - mem_rd=1 for cycles 1..8, with mem_addr 0x0000,0x0002,...,0x000E.
  - Cycle 13: stall=0 and inst = memory word 0.
- Hit after fill: addr=0x000A.
  - Same cycle: stall=0, inst = memory word 5, mem_rd stays 0.
- Conflict eviction: fill 0x0000, then fetch 0x0200 (same index 0, tag 1).
  - Miss with a 13-cycle stall and a fill from 0x0200..0x020E.
  - Re-fetching 0x0000 then misses again.
- Reset mid-fill: assert rst_n=0 at the 6th cycle of FILL.
  - stall=0 and mem_rd=0 immediately.
  - Late mem_valid pulses are ignored.
  - After release, addr=0x0000 misses again with the full penalty.
- Address change during fill: miss on 0x0010, then addr switches to 0x0100 mid-fill.
  - The fill still completes for line 1, addresses 0x0010..0x001E.
  - Afterwards 0x0100 misses and is filled.
- Perf counters (ICACHE_PERF_CNT_EN): cold miss on 0x0000 followed by 7 sequential hits (0x0002..0x000E).
  - Result: miss_cnt=1, hit_cnt=8, counting the post-fill hit on 0x0000.
